// File: rtl/sobel_stream_if.sv
// sobel_stream_if: pixel-stream bundle for sobel_stream, input stream plus threshold
// controls towards the filter and the filtered stream back.
interface sobel_stream_if #(
    parameter int PIX_W = 8
);
    logic             in_valid;
    logic [PIX_W-1:0] in_pixel;
    logic             in_sof;
    logic             thresh_en;
    logic [PIX_W-1:0] thresh;
    logic             out_valid;
    logic [PIX_W-1:0] out_pixel;
    logic             out_sof;
    modport master (
        output in_valid, in_pixel, in_sof, thresh_en, thresh,
        input  out_valid, out_pixel, out_sof
    );
    modport slave (
        input  in_valid, in_pixel, in_sof, thresh_en, thresh,
        output out_valid, out_pixel, out_sof
    );
endinterface

// File: rtl/sobel_stream.sv
// sobel_stream: 3-stage streaming 3x3 Sobel/Prewitt edge filter with two line
// buffers, border masking, magnitude saturation and optional binarisation.
module sobel_stream #(
    parameter int PIX_W  = 8,
    parameter int IMG_W  = 640,
    parameter int KERNEL = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    sobel_stream_if.slave  bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int GW = PIX_W + 3;
    localparam int MW = PIX_W + 4;
    localparam int WS = (KERNEL == 0) ? 1 : 0;
    localparam logic [PIX_W-1:0] MAXV = '1;

    logic [CW-1:0]           r_col;
    logic [1:0]              r_row;
    logic [PIX_W-1:0]        r_lb0 [IMG_W];
    logic [PIX_W-1:0]        r_lb1 [IMG_W];
    logic [PIX_W-1:0]        r_p   [9];
    logic                    r_v1, r_sof1, r_mask1;
    logic                    r_v2, r_sof2, r_mask2;
    logic signed [GW-1:0]    r_gx, r_gy;

    logic [CW-1:0]           w_col, w_col_nx;
    logic [1:0]              w_row, w_row_nx;
    logic                    w_border;
    logic signed [GW-1:0]    w_t [9];
    logic signed [GW-1:0]    w_gx, w_gy;
    logic [GW-1:0]           w_ax, w_ay;
    logic [MW-1:0]           w_sum;
    logic [PIX_W-1:0]        w_mag, w_res;

    // A start-of-frame pixel overrides whatever position the counters hold.
    always_comb begin
        w_col    = bus.in_sof ? '0 : r_col;
        w_row    = bus.in_sof ? '0 : r_row;
        w_col_nx = (w_col == CW'(IMG_W - 1)) ? '0 : w_col + 1'b1;
        w_row_nx = (w_col != CW'(IMG_W - 1)) ? w_row : (w_row == 2'd2) ? 2'd2 : w_row + 2'd1;
        w_border = (w_row < 2'd2) || (w_col < CW'(2));
    end

    always_comb begin
        for (int i = 0; i < 9; i++) w_t[i] = $signed({3'b000, r_p[i]});
        w_gx  = (w_t[2] + (w_t[5] <<< WS) + w_t[8]) - (w_t[0] + (w_t[3] <<< WS) + w_t[6]);
        w_gy  = (w_t[0] + (w_t[1] <<< WS) + w_t[2]) - (w_t[6] + (w_t[7] <<< WS) + w_t[8]);
        w_ax  = r_gx[GW-1] ? -r_gx : r_gx;
        w_ay  = r_gy[GW-1] ? -r_gy : r_gy;
        w_sum = {1'b0, w_ax} + {1'b0, w_ay};
        w_mag = (w_sum > MW'(MAXV)) ? MAXV : w_sum[PIX_W-1:0];
        w_res = bus.thresh_en ? ((w_mag >= bus.thresh) ? MAXV : '0) : w_mag;
    end

    // Pixel storage is deliberately unreset; border masking hides stale contents.
    always_ff @(posedge clk) begin
        if (bus.in_valid) begin
            r_lb0[w_col] <= bus.in_pixel;
            r_lb1[w_col] <= r_lb0[w_col];
            r_p[0] <= r_p[1];
            r_p[1] <= r_p[2];
            r_p[2] <= r_lb1[w_col];
            r_p[3] <= r_p[4];
            r_p[4] <= r_p[5];
            r_p[5] <= r_lb0[w_col];
            r_p[6] <= r_p[7];
            r_p[7] <= r_p[8];
            r_p[8] <= bus.in_pixel;
        end
        r_gx <= w_gx;
        r_gy <= w_gy;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col         <= '0;
            r_row         <= '0;
            r_v1          <= 1'b0;
            r_sof1        <= 1'b0;
            r_mask1       <= 1'b0;
            r_v2          <= 1'b0;
            r_sof2        <= 1'b0;
            r_mask2       <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_sof   <= 1'b0;
            bus.out_pixel <= '0;
        end else begin
            if (bus.in_valid) begin
                r_col <= w_col_nx;
                r_row <= w_row_nx;
            end
            r_v1          <= bus.in_valid;
            r_sof1        <= bus.in_valid & bus.in_sof;
            r_mask1       <= w_border;
            r_v2          <= r_v1;
            r_sof2        <= r_sof1;
            r_mask2       <= r_mask1;
            bus.out_valid <= r_v2;
            bus.out_sof   <= r_v2 & r_sof2;
            bus.out_pixel <= (r_v2 && !r_mask2) ? w_res : '0;
        end
    end
endmodule

// File: tb/tb_sobel_stream.sv
// tb_sobel_stream: drives a Sobel and a Prewitt instance with directed frames and
// checks both against a frame-image model plus hand-computed literal values.
module tb_sobel_stream;
    localparam int PW = 8;
    localparam int IW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic iv = 1'b0, is = 1'b0, te = 1'b0;
    logic [PW-1:0] ip = '0, th = '0;

    always #5 clk = ~clk;

    sobel_stream_if #(.PIX_W(PW)) b0 ();
    sobel_stream_if #(.PIX_W(PW)) b1 ();
    assign b0.in_valid = iv;
    assign b0.in_pixel = ip;
    assign b0.in_sof = is;
    assign b0.thresh_en = te;
    assign b0.thresh = th;
    assign b1.in_valid = iv;
    assign b1.in_pixel = ip;
    assign b1.in_sof = is;
    assign b1.thresh_en = te;
    assign b1.thresh = th;

    sobel_stream #(.PIX_W(PW), .IMG_W(IW), .KERNEL(0)) d0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    sobel_stream #(.PIX_W(PW), .IMG_W(IW), .KERNEL(1)) d1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    int checks = 0, errors = 0;
    int img [64][IW];
    int q0 [$];
    int q1 [$];
    logic [2:0] hist = '0;
    int mrow = 0, mcol = 0;
    int log0 [256];
    int log1 [256];
    int ref0 [256];
    int oi0 = 0, oi1 = 0;

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Expected output for the pixel at frame position (r,c), from the full image.
    function automatic int model_out(input int r, input int c, input int w, input bit t_en, input int t);
        int p [9];
        int gx, gy, mag;
        if (r < 2 || c < 2) return 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                p[i*3+j] = img[(r-2+i) % 64][c-2+j];
        gx  = (p[2] + w*p[5] + p[8]) - (p[0] + w*p[3] + p[6]);
        gy  = (p[0] + w*p[1] + p[2]) - (p[6] + w*p[7] + p[8]);
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (mag > 255) mag = 255;
        if (t_en) return (mag >= t) ? 255 : 0;
        return mag;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist = '0;
            q0.delete();
            q1.delete();
            mrow = 0;
            mcol = 0;
        end else begin
            hist = {hist[1:0], iv};
            if (iv) begin
                if (is) begin
                    mrow = 0;
                    mcol = 0;
                end
                img[mrow % 64][mcol] = int'(ip);
                q0.push_back(model_out(mrow, mcol, 2, te, int'(th)) + (is ? 65536 : 0));
                q1.push_back(model_out(mrow, mcol, 1, te, int'(th)) + (is ? 65536 : 0));
                mcol++;
                if (mcol == IW) begin
                    mcol = 0;
                    mrow++;
                end
            end
        end
    end

    always @(negedge clk) begin
        int e;
        if (!rst_n) begin
            chk("rst_hold_valid0", int'(b0.out_valid), 0);
            chk("rst_hold_valid1", int'(b1.out_valid), 0);
            oi0 = 0;
            oi1 = 0;
        end else begin
            chk("valid0", int'(b0.out_valid), int'(hist[2]));
            chk("valid1", int'(b1.out_valid), int'(hist[2]));
            if (b0.out_valid) begin
                if (q0.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL q0_empty got=out_valid expected=no output");
                end else begin
                    e = q0.pop_front();
                    chk("pix0", int'(b0.out_pixel), e & 'hffff);
                    chk("sof0", int'(b0.out_sof), e >> 16);
                end
                if (b0.out_sof) oi0 = 0;
                if (oi0 < 256) log0[oi0] = int'(b0.out_pixel);
                oi0++;
            end else begin
                chk("idle_pix0", int'(b0.out_pixel), 0);
                chk("idle_sof0", int'(b0.out_sof), 0);
            end
            if (b1.out_valid) begin
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL q1_empty got=out_valid expected=no output");
                end else begin
                    e = q1.pop_front();
                    chk("pix1", int'(b1.out_pixel), e & 'hffff);
                    chk("sof1", int'(b1.out_sof), e >> 16);
                end
                if (b1.out_sof) oi1 = 0;
                if (oi1 < 256) log1[oi1] = int'(b1.out_pixel);
                oi1++;
            end else begin
                chk("idle_pix1", int'(b1.out_pixel), 0);
                chk("idle_sof1", int'(b1.out_sof), 0);
            end
        end
    end

    task automatic send(input bit v, input int pix, input bit sof);
        @(posedge clk);
        #1;
        iv = v;
        ip = PW'(pix);
        is = sof;
    endtask

    task automatic drain();
        repeat (6) send(0, 0, 0);
    endtask

    task automatic frame(input int rows, input int lo, input int hi, input bit gaps, input bit sof);
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < IW; c++) begin
                if (gaps) while ($urandom_range(0, 1) == 1) send(0, 0, 0);
                send(1, (c >= 4) ? hi : lo, sof && r == 0 && c == 0);
            end
    endtask

    task automatic rst_out_chk(input string nm);
        chk({nm, "_valid0"}, int'(b0.out_valid), 0);
        chk({nm, "_pix0"}, int'(b0.out_pixel), 0);
        chk({nm, "_sof0"}, int'(b0.out_sof), 0);
        chk({nm, "_valid1"}, int'(b1.out_valid), 0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 rst_out_chk("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        frame(4, 100, 100, 0, 1);
        drain();
        chk("uniform_k0", log0[27], 0);
        chk("uniform_k1", log1[27], 0);

        frame(4, 0, 255, 0, 1);
        drain();
        chk("step255_r2c4", log0[20], 255);
        chk("step255_r2c5", log0[21], 255);
        chk("step255_r2c3", log0[19], 0);
        chk("step255_r2c6", log0[22], 0);
        chk("step255_r3c4", log0[28], 255);
        chk("step255_r1c4", log0[12], 0);
        for (int i = 0; i < 32; i++) ref0[i] = log0[i];

        frame(4, 0, 60, 0, 1);
        drain();
        chk("step60_k1_c4", log1[20], 180);
        chk("step60_k1_c5", log1[21], 180);
        chk("step60_k1_c6", log1[22], 0);
        chk("step60_k0_c4", log0[20], 240);

        te = 1'b1;
        th = 8'd180;
        frame(4, 0, 60, 0, 1);
        drain();
        chk("thr180_c4", log1[20], 255);
        chk("thr180_c5", log1[21], 255);
        chk("thr180_c6", log1[22], 0);

        th = 8'd181;
        frame(4, 0, 60, 0, 1);
        drain();
        chk("thr181_c4", log1[20], 0);
        chk("thr181_k0_c4", log0[20], 255);

        th = 8'd0;
        frame(4, 100, 100, 0, 1);
        drain();
        chk("thr0_interior", log0[27], 255);
        chk("thr0_row1", log0[9], 0);
        chk("thr0_col0", log0[16], 0);
        chk("thr0_col1", log1[25], 0);

        te = 1'b0;
        frame(4, 0, 255, 1, 1);
        drain();
        chk("gap_count", oi0, 32);
        for (int i = 0; i < 32; i++) chk($sformatf("gap_idx%0d", i), log0[i], ref0[i]);

        frame(3, 0, 255, 0, 1);
        for (int c = 0; c < 5; c++) send(1, (c >= 4) ? 255 : 0, 0);
        frame(3, 0, 255, 0, 1);
        drain();
        chk("midsof_count", oi0, 24);
        for (int i = 0; i < 16; i++) chk($sformatf("midsof_mask%0d", i), log0[i], 0);
        chk("midsof_r2c4", log0[20], 255);

        frame(2, 0, 255, 0, 1);
        for (int c = 0; c < 3; c++) send(1, 0, 0);
        @(posedge clk);
        #2 chk("pre_rst_valid", int'(b0.out_valid), 1);
        #1 rst_n = 1'b0;
        iv = 1'b0;
        #1 rst_out_chk("async_rst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        frame(3, 0, 255, 0, 0);
        drain();
        chk("post_rst_count", oi0, 24);
        chk("post_rst_r2c4", log0[20], 255);
        chk("post_rst_r1c4", log0[12], 0);
        chk("post_rst_r2c6", log0[22], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
